sd_otf_converter: RTL and testbench
===================================

Name: sd_otf_converter

Overview:
- Receive end of the radix-2 online datapath: accepts an MSD-first serial signed-digit stream on a positive/negative rail pair, as produced by the serial online adders.
- Converts it on the fly to a conventional two's-complement word, with no carry-propagate adder after the last digit.
- One word is emitted per frame of N digits, held under a valid/ready handshake.
- Sits at the boundary between the online arithmetic core and the parallel host logic.

Parameters:
- N, 8, number of signed digits per frame; result width is N+1.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- din_valid  in  1  digit present on dinp/dinn this cycle
- din_ready  out  1  converter accepts a digit this cycle
- din_first  in  1  marks the digit as MSD of a new frame (resync)
- dinp  in  1  positive rail of digit
- dinn  in  1  negative rail of digit
- dout  out  N+1  two's-complement result, integer weight: sum d_i*2^(N-i), i=1..N
- dout_valid  out  1  dout holds a completed frame
- dout_ready  in  1  consumer takes dout
- frame_err  out  1  one-cycle pulse when a frame is abandoned by resync

Behaviour:
- Digit value d = dinp - dinn. Encoding 00 and 11 mean 0, 10 means +1, 01 means -1.
- Digit transfer occurs when din_valid && din_ready. No other cycle changes the converter state, except the output handshake.
- State:
  - Q and QM registers, both N+1 bits.
  - Digit counter cnt, 0..N-1.
  - Output register dout plus dout_valid.
- Invariant: QM == Q-1 at all times.
- Frame start, at cnt==0 or on a resync: operands are Q=0, QM=all-ones.
- On-the-fly update per accepted digit (x = current Q/QM, or the frame-start values):
  - d=+1: Q<=2Q+1, QM<=2Q
  - d=0: Q<=2Q, QM<=2QM+1
  - d=-1: Q<=2QM+1, QM<=2QM
- Shifts are within N+1 bits. Range ±(2^N-1) always fits, so there is no overflow case.
- Completion: on the accepted digit with cnt==N-1:
  - The updated Q value is loaded into dout, dout_valid<=1, and cnt<=0.
  - Latency: dout_valid rises the cycle after the N-th digit's transfer edge.
- Output handshake:
  - dout_valid is cleared by dout_valid && dout_ready, unless a new completion occurs in the same cycle. In that case dout is reloaded and dout_valid stays 1.
  - dout is stable while dout_valid && !dout_ready.
- din_ready = !(dout_valid && !dout_ready && cnt==N-1).
  - Only the final digit of a frame stalls while the previous result is unconsumed. Earlier digits proceed.
  - Back-to-back frames at full rate are supported when dout_ready is held high.
- din_first:
  - Accepted with cnt==0: normal, no effect.
  - Accepted with cnt!=0: the partial frame is discarded. This digit is treated as digit 1 of a new frame (frame-start operands, cnt<=1), and frame_err pulses for one cycle.
  - If N==1, the digit completes immediately.
- din_first without din_valid is ignored.
- Reset (asynchronous, any time including mid-frame):
  - Q=0, QM=all-ones, cnt=0, dout=0, dout_valid=0, frame_err=0.
  - The partial frame is lost silently, with no frame_err.
- din_ready is combinational from the state and dout_ready. There is no combinational path from dinp/dinn to any output.

Decomposition:
- Shared package (online arithmetic): digit-encoding constants SD_ZERO=2'b00, SD_POS=2'b10, SD_NEG=2'b01, SD_ZERO_ALT=2'b11, and the signed-digit type, so the adders and the converter agree.
- One natural sub-module: sd_otf_step, a combinational next-Q/QM from (Q, QM, dinp, dinn), parameterised by width and reusable by a future radix-4 variant.
- Counter, handshake and output register stay in the top module.

Test Plan:
- N=4, dout_ready=1, digits +1,0,-1,+1 (din_first on first) -> one dout_valid pulse with dout=5'b00111 (7), one cycle after the 4th digit.
- N=4, digits -1,-1,-1,-1 then +1,-1,0,0 back-to-back -> dout=5'b10001 (-15), then dout=5'b00100 (4) on consecutive frame boundaries with no stall.
- N=4, frame of all 11 encodings -> dout=0. Frame 10,11,00,01 -> dout=8-1=7.
- Backpressure, N=4:
  - dout_ready=0 after the first result. din_ready stays 1 for digits 1-3 of the next frame, then drops at the 4th digit with dout unchanged.
  - Raising dout_ready -> the 4th digit is accepted in that cycle, and the new result appears next cycle.
- Resync, N=4: digits +1,+1, then din_first with -1, then 0,0,+1 -> frame_err pulse once, dout=5'b11001 (-7).
- Assert rst_n=0 after 2 digits -> outputs zero immediately, no frame_err. After release, a full frame +1,+1,+1,+1 -> dout=15.

Source files
------------

// File: rtl/sd_otf_converter_pkg.sv
// Shared online-arithmetic definitions: signed-digit rail encoding used by the
// serial adders and by the on-the-fly converter.
package sd_otf_converter_pkg;

  localparam int SD_W = 2;

  // Rail pair {p, n}; both 00 and 11 carry the value zero.
  typedef enum logic [SD_W-1:0] {
    SD_ZERO     = 2'b00,
    SD_NEG      = 2'b01,
    SD_POS      = 2'b10,
    SD_ZERO_ALT = 2'b11
  } sd_digit_e;

  function automatic sd_digit_e sd_decode(input logic p, input logic n);
    return sd_digit_e'({p, n});
  endfunction

endpackage

// File: rtl/sd_otf_step.sv
// One radix-2 on-the-fly conversion step: next Q/QM from the current pair and
// one signed digit. Purely combinational.
module sd_otf_step
  import sd_otf_converter_pkg::*;
#(
  parameter int W = 9
) (
  input  logic [W-1:0] q,
  input  logic [W-1:0] qm,
  input  logic         dinp,
  input  logic         dinn,
  output logic [W-1:0] q_nxt,
  output logic [W-1:0] qm_nxt
);

  // Select shifted source and appended bit according to the digit value.
  always_comb begin
    q_nxt  = {q[W-2:0], 1'b0};
    qm_nxt = {qm[W-2:0], 1'b1};
    case (sd_decode(dinp, dinn))
      SD_POS: begin
        q_nxt  = {q[W-2:0], 1'b1};
        qm_nxt = {q[W-2:0], 1'b0};
      end
      SD_NEG: begin
        q_nxt  = {qm[W-2:0], 1'b1};
        qm_nxt = {qm[W-2:0], 1'b0};
      end
      SD_ZERO, SD_ZERO_ALT: begin
        q_nxt  = {q[W-2:0], 1'b0};
        qm_nxt = {qm[W-2:0], 1'b1};
      end
      default: begin
        q_nxt  = {q[W-2:0], 1'b0};
        qm_nxt = {qm[W-2:0], 1'b1};
      end
    endcase
  end

endmodule

// File: rtl/sd_otf_converter.sv
// Serial MSD-first signed-digit stream to two's-complement word converter with
// a valid/ready result register and resync on din_first.
module sd_otf_converter
  import sd_otf_converter_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         din_valid,
  output logic         din_ready,
  input  logic         din_first,
  input  logic         dinp,
  input  logic         dinn,
  output logic [N:0]   dout,
  output logic         dout_valid,
  input  logic         dout_ready,
  output logic         frame_err
);

  localparam int W     = N + 1;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [W-1:0]     q_q, q_d, qm_q, qm_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             frame_err_q, frame_err_d;

  logic [W-1:0] op_q_s, op_qm_s, step_q_s, step_qm_s;
  logic         last_s, xfer_s, resync_s, start_s, complete_s;

  assign last_s    = (cnt_q == CNT_LAST);
  assign din_ready = !(dout_valid_q && !dout_ready && last_s);
  assign xfer_s    = din_valid && din_ready;
  assign resync_s  = xfer_s && din_first && (cnt_q != CNT_ZERO);
  assign start_s   = (cnt_q == CNT_ZERO) || resync_s;
  // A resync digit becomes digit 1, so it only completes when N is 1.
  assign complete_s = xfer_s && (resync_s ? (N == 1) : last_s);

  assign op_q_s  = start_s ? {W{1'b0}} : q_q;
  assign op_qm_s = start_s ? {W{1'b1}} : qm_q;

  sd_otf_step #(.W(W)) u_step (
    .q      (op_q_s),
    .qm     (op_qm_s),
    .dinp   (dinp),
    .dinn   (dinn),
    .q_nxt  (step_q_s),
    .qm_nxt (step_qm_s)
  );

  // Next-state for the conversion pair, digit counter and result register.
  always_comb begin
    q_d          = q_q;
    qm_d         = qm_q;
    cnt_d        = cnt_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    frame_err_d  = resync_s;

    if (xfer_s) begin
      q_d  = step_q_s;
      qm_d = step_qm_s;
      if (resync_s) begin
        cnt_d = (N == 1) ? CNT_ZERO : CNT_ONE;
      end else if (last_s) begin
        cnt_d = CNT_ZERO;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else begin
      cnt_d = cnt_q;
    end

    if (complete_s) begin
      dout_d       = step_q_s;
      dout_valid_d = 1'b1;
    end else if (dout_valid_q && dout_ready) begin
      dout_valid_d = 1'b0;
    end else begin
      dout_valid_d = dout_valid_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q          <= {W{1'b0}};
      qm_q         <= {W{1'b1}};
      cnt_q        <= CNT_ZERO;
      dout_q       <= {W{1'b0}};
      dout_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      q_q          <= q_d;
      qm_q         <= qm_d;
      cnt_q        <= cnt_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_sd_otf_converter.sv
// Bench for sd_otf_converter (N=4): directed frame table, backpressure, resync
// and reset sequences, then random traffic against a value-level model.
module tb_sd_otf_converter;

  localparam int N = 4;
  localparam int W = N + 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         din_valid = 1'b0;
  logic         din_first = 1'b0;
  logic         dinp = 1'b0;
  logic         dinn = 1'b0;
  logic         dout_ready = 1'b0;
  logic         din_ready;
  logic         dout_valid;
  logic         frame_err;
  logic [W-1:0] dout;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sd_otf_converter #(.N(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .din_first  (din_first),
    .dinp       (dinp),
    .dinn       (dinn),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .frame_err  (frame_err)
  );

  typedef struct {
    logic [2*N-1:0] digits;
    logic [W-1:0]   exp;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic send_digit(input logic [1:0] enc, input logic first, output int stalls);
    stalls = 0;
    din_valid = 1'b1;
    {dinp, dinn} = enc;
    din_first = first;
    @(negedge clk);
    while (!din_ready && stalls < 50) begin
      stalls++;
      @(negedge clk);
    end
    if (!din_ready) chk("send_timeout", {31'd0, din_ready}, 32'd1);
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    din_first = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int     stalls;
    int     m_acc, m_nd, m_out, d;
    logic   m_v, m_err, exp_rdy, xfer, consume, done;
    logic [W-1:0] em;

    vecs[0] = '{digits: 8'b10_00_01_10, exp: 5'b00111};
    vecs[1] = '{digits: 8'b01_01_01_01, exp: 5'b10001};
    vecs[2] = '{digits: 8'b10_01_00_00, exp: 5'b00100};
    vecs[3] = '{digits: 8'b11_11_11_11, exp: 5'b00000};
    vecs[4] = '{digits: 8'b10_11_00_01, exp: 5'b00111};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dout", {27'd0, dout}, 32'd0);
    chk("rst_dout_valid", {31'd0, dout_valid}, 32'd0);
    chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
    chk("rst_din_ready", {31'd0, din_ready}, 32'd1);
    rst_n = 1'b1;
    dout_ready = 1'b1;
    @(posedge clk);
    #1;

    // Frame table, back-to-back with the consumer always ready
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < N; j++) begin
        send_digit(vecs[i].digits[2*N-1-2*j -: 2], (j == 0), stalls);
        chk("tbl_no_stall", stalls, 32'd0);
        chk("tbl_frame_err", {31'd0, frame_err}, 32'd0);
        if (j == N - 2) chk("tbl_not_yet_valid", {31'd0, dout_valid}, 32'd0);
      end
      chk("tbl_valid", {31'd0, dout_valid}, 32'd1);
      chk("tbl_dout", {27'd0, dout}, {27'd0, vecs[i].exp});
    end

    // Backpressure: result 15 held, next frame's last digit stalls
    for (int j = 0; j < N; j++) send_digit(2'b10, (j == 0), stalls);
    dout_ready = 1'b0;
    chk("bp_first_dout", {27'd0, dout}, 32'd15);
    send_digit(2'b00, 1'b1, stalls);
    chk("bp_d1_no_stall", stalls, 32'd0);
    send_digit(2'b10, 1'b0, stalls);
    chk("bp_d2_no_stall", stalls, 32'd0);
    send_digit(2'b01, 1'b0, stalls);
    chk("bp_d3_no_stall", stalls, 32'd0);
    din_valid = 1'b1;
    {dinp, dinn} = 2'b10;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_stall_ready", {31'd0, din_ready}, 32'd0);
      chk("bp_stall_dout", {27'd0, dout}, 32'd15);
      chk("bp_stall_valid", {31'd0, dout_valid}, 32'd1);
    end
    dout_ready = 1'b1;
    #1;
    chk("bp_release_ready", {31'd0, din_ready}, 32'd1);
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    chk("bp_new_valid", {31'd0, dout_valid}, 32'd1);
    chk("bp_new_dout", {27'd0, dout}, 32'd3);

    // Resync mid-frame
    send_digit(2'b10, 1'b1, stalls);
    send_digit(2'b10, 1'b0, stalls);
    chk("rs_no_err_yet", {31'd0, frame_err}, 32'd0);
    send_digit(2'b01, 1'b1, stalls);
    chk("rs_err_pulse", {31'd0, frame_err}, 32'd1);
    send_digit(2'b00, 1'b0, stalls);
    chk("rs_err_cleared", {31'd0, frame_err}, 32'd0);
    send_digit(2'b00, 1'b0, stalls);
    chk("rs_not_yet_valid", {31'd0, dout_valid}, 32'd0);
    send_digit(2'b10, 1'b0, stalls);
    chk("rs_valid", {31'd0, dout_valid}, 32'd1);
    chk("rs_dout", {27'd0, dout}, 32'h19);

    // Asynchronous reset mid-frame, then a frame without din_first
    send_digit(2'b10, 1'b1, stalls);
    send_digit(2'b10, 1'b0, stalls);
    rst_n = 1'b0;
    #1;
    chk("ar_dout", {27'd0, dout}, 32'd0);
    chk("ar_valid", {31'd0, dout_valid}, 32'd0);
    chk("ar_frame_err", {31'd0, frame_err}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int j = 0; j < N; j++) begin
      send_digit(2'b10, 1'b0, stalls);
      chk("ar_frame_err_after", {31'd0, frame_err}, 32'd0);
    end
    chk("ar_valid_after", {31'd0, dout_valid}, 32'd1);
    chk("ar_dout_after", {27'd0, dout}, 32'd15);

    // Random traffic against a value-level model
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_acc = 0; m_nd = 0; m_out = 0; m_v = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      din_valid    = ($urandom_range(0, 9) < 7);
      {dinp, dinn} = 2'($urandom_range(0, 3));
      din_first    = ($urandom_range(0, 9) == 0);
      dout_ready   = ($urandom_range(0, 9) < 6);
      @(negedge clk);
      exp_rdy = !(m_v && !dout_ready && m_nd == N - 1);
      chk("rnd_din_ready", {31'd0, din_ready}, {31'd0, exp_rdy});
      xfer    = din_valid && exp_rdy;
      consume = m_v && dout_ready;
      d       = int'(dinp) - int'(dinn);
      m_err   = 1'b0;
      done    = 1'b0;
      if (xfer) begin
        if (din_first && m_nd != 0) m_err = 1'b1;
        if (m_nd == 0 || din_first) begin
          m_acc = d;
          m_nd  = 1;
        end else begin
          m_acc = 2 * m_acc + d;
          m_nd++;
        end
        if (m_nd == N) begin
          m_nd  = 0;
          m_out = m_acc;
          m_v   = 1'b1;
          done  = 1'b1;
        end
      end
      if (!done && consume) m_v = 1'b0;
      @(posedge clk);
      #1;
      chk("rnd_dout_valid", {31'd0, dout_valid}, {31'd0, m_v});
      chk("rnd_frame_err", {31'd0, frame_err}, {31'd0, m_err});
      if (m_v) begin
        em = m_out[W-1:0];
        chk("rnd_dout", {27'd0, dout}, {27'd0, em});
      end
    end
    din_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
